piton_endp_link: RTL

//  Endpoint-side link adapter for one local port of the piton mesh (valid/data/yummy credit protocol).
//  TX half: takes flits from a local valid/ready source and drives dataOut/validOut toward the

---
 rtl/piton_endp_link.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/piton_endp_link.sv
// Endpoint-side piton link adapter: credit-gated TX toward the router LOCAL input,
// FIFO-buffered RX from the router LOCAL output with one yummy returned per consumed flit.
module piton_endp_link #(
    parameter int FLIT_W   = 64,
    parameter int CREDITS  = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,

    input  logic [FLIT_W-1:0]              tx_data_i,
    input  logic                           tx_valid_i,
    output logic                           tx_ready_o,

    output logic [FLIT_W-1:0]              dataOut,
    output logic                           validOut,
    input  logic                           yummyIn,

    input  logic [FLIT_W-1:0]              dataIn,
    input  logic                           validIn,
    output logic                           yummyOut,

    output logic [FLIT_W-1:0]              rx_data_o,
    output logic                           rx_valid_o,
    input  logic                           rx_ready_i,

    output logic [$clog2(CREDITS+1)-1:0]   credit_cnt_o,
    output logic [1:0]                     err_o
);

    localparam int CW = $clog2(CREDITS + 1);
    localparam int PW = $clog2(RX_DEPTH);
    localparam int OW = $clog2(RX_DEPTH + 1);

    // ------------------------------------------------------------------
    // TX half
    // ------------------------------------------------------------------
    logic [CW-1:0]     credit_q, credit_d;
    logic              valid_out_q;
    logic [FLIT_W-1:0] data_out_q;
    logic              tx_hs;
    logic              yummy_at_full;

    assign tx_ready_o = (credit_q != '0);
    assign tx_hs      = tx_valid_i & tx_ready_o;

    // A yummy arriving with a simultaneous send cancels out; one at full credit is a protocol error.
    always_comb begin
        credit_d      = credit_q;
        yummy_at_full = 1'b0;
        case ({tx_hs, yummyIn})
            2'b10:   credit_d = credit_q - CW'(1);
            2'b01: begin
                if (credit_q == CW'(CREDITS)) begin
                    yummy_at_full = 1'b1;
                end else begin
                    credit_d = credit_q + CW'(1);
                end
            end
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_q    <= CW'(CREDITS);
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            credit_q    <= credit_d;
            valid_out_q <= tx_hs;
            if (tx_hs) begin
                data_out_q <= tx_data_i;
            end
        end
    end

    assign validOut     = valid_out_q;
    assign dataOut      = data_out_q;
    assign credit_cnt_o = credit_q;

    // ------------------------------------------------------------------
    // RX half
    // ------------------------------------------------------------------
    logic [FLIT_W-1:0] rx_mem [RX_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]     occ_q, occ_d;
    logic              rx_full;
    logic              rx_pop;
    logic              rx_push;
    logic              rx_ovf;
    logic              yummy_out_q;

    assign rx_valid_o = (occ_q != '0);
    assign rx_full    = (occ_q == OW'(RX_DEPTH));
    assign rx_pop     = rx_valid_o & rx_ready_i;
    // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
    assign rx_push    = validIn & (~rx_full | rx_pop);
    assign rx_ovf     = validIn & rx_full & ~rx_pop;

    always_comb begin
        occ_d = occ_q;
        case ({rx_push, rx_pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            yummy_out_q <= 1'b0;
        end else begin
            occ_q       <= occ_d;
            yummy_out_q <= rx_pop;
            if (rx_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (rx_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Storage needs no reset: the occupancy counter decides what is visible.
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[wr_ptr_q] <= dataIn;
        end
    end

    assign rx_data_o = rx_valid_o ? rx_mem[rd_ptr_q] : '0;
    assign yummyOut  = yummy_out_q;

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    logic [1:0] err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 2'b00;
        end else begin
            err_q <= err_q | {rx_ovf, yummy_at_full};
        end
    end

    assign err_o = err_q;

endmodule
